// File: rtl/branch_commit_unit_pkg.sv
// Shared definitions for the branch commit unit: ROB index width,
// branch-result bit positions and a small mispredict helper.
package branch_commit_unit_pkg;

    // Width of a reorder-buffer index.
    localparam int ROB_ENTRY_WIDTH = 6;

    // Bit positions inside the 2-bit branch result {predicted, actual}.
    localparam int RES_PRED_BIT    = 1;
    localparam int RES_ACTUAL_BIT  = 0;

    // Default instruction address width.
    localparam int BRANCH_ADDR_W   = 32;

    // Decoded branch result.
    typedef struct packed {
        logic pred;
        logic actual;
    } bra_result_t;

    // A retired branch mispredicted when its guess differs from the outcome.
    function automatic logic is_mispredict(input logic pred, input logic actual);
        return pred != actual;
    endfunction

endpackage

// File: rtl/branch_cam_match.sv
// DEPTH-wide ROB index comparator. Only entries flagged eligible (busy and
// still waiting for a result) can match; the result is one-hot by contract.
module branch_cam_match #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 6
) (
    input  logic             search_valid,
    input  logic [IDX_W-1:0] search_index,
    input  logic [DEPTH-1:0] entry_eligible,
    input  logic [IDX_W-1:0] entry_index [DEPTH],
    output logic [DEPTH-1:0] match_onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
            // One comparator per entry
            assign match_onehot[gi] = search_valid && entry_eligible[gi]
                                      && (entry_index[gi] == search_index);
        end
    endgenerate

endmodule

// File: rtl/branch_commit_unit.sv
// In-order branch retirement queue. Branches are allocated at dispatch,
// resolved out of order by ROB index, and retired from the head one per
// cycle. A mispredicted retirement flushes the whole queue and redirects
// fetch to the alternate PC.
module branch_commit_unit
    import branch_commit_unit_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int IDX_W  = ROB_ENTRY_WIDTH,
    parameter int ADDR_W = BRANCH_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [IDX_W-1:0]  alloc_rob_index,
    input  logic [ADDR_W-1:0] alloc_pc,
    input  logic [ADDR_W-1:0] alloc_alt_pc,
    output logic              alloc_stall,
    input  logic              bra_in_valid,
    input  logic [IDX_W-1:0]  bra_in_index,
    input  logic [1:0]        bra_in_result,
    output logic              commit_valid,
    output logic [IDX_W-1:0]  commit_rob_index,
    output logic              flush_out,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              bp_update_valid,
    output logic [ADDR_W-1:0] bp_update_pc,
    output logic              bp_update_taken
);

    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [PTR_W:0]    head_reg, tail_reg;
    logic [PTR_W-1:0]  head_slot, tail_slot;
    logic              full;

    // Per-entry state gathered from the generate blocks below.
    logic [DEPTH-1:0]  busy_vec, resolved_vec, pred_vec, actual_vec;
    logic [IDX_W-1:0]  rob_index_arr [DEPTH];
    logic [ADDR_W-1:0] pc_arr        [DEPTH];
    logic [ADDR_W-1:0] alt_pc_arr    [DEPTH];

    logic [DEPTH-1:0]  match_onehot;
    logic              retire_now, flush_now, alloc_fire;
    bra_result_t       res;

    assign head_slot   = head_reg[PTR_W-1:0];
    assign tail_slot   = tail_reg[PTR_W-1:0];
    assign full        = (head_reg[PTR_W] != tail_reg[PTR_W]) && (head_slot == tail_slot);
    assign alloc_stall = full;

    assign res.pred    = bra_in_result[RES_PRED_BIT];
    assign res.actual  = bra_in_result[RES_ACTUAL_BIT];

    // Retirement looks only at registered state; a resolve landing this
    // cycle cannot retire until the following edge.
    assign retire_now  = busy_vec[head_slot] && resolved_vec[head_slot];
    assign flush_now   = retire_now && is_mispredict(pred_vec[head_slot], actual_vec[head_slot]);
    // Conservative: a full queue refuses allocation even if the head retires.
    assign alloc_fire  = alloc_valid && !full && !flush_now;

    branch_cam_match #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_cam (
        .search_valid   (bra_in_valid),
        .search_index   (bra_in_index),
        .entry_eligible (busy_vec & ~resolved_vec),
        .entry_index    (rob_index_arr),
        .match_onehot   (match_onehot)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [PTR_W-1:0] SLOT = PTR_W'(gi);

            logic              busy_reg, resolved_reg, pred_reg, actual_reg;
            logic [IDX_W-1:0]  rob_index_reg;
            logic [ADDR_W-1:0] pc_reg, alt_pc_reg;

            // Entry status: allocate, retire, resolve; flush clears everything
            always_ff @(posedge clk) begin
                if (rst || flush_now) begin
                    busy_reg     <= 1'b0;
                    resolved_reg <= 1'b0;
                end else if (alloc_fire && tail_slot == SLOT) begin
                    busy_reg     <= 1'b1;
                    resolved_reg <= 1'b0;
                end else if (retire_now && head_slot == SLOT) begin
                    busy_reg     <= 1'b0;
                    resolved_reg <= 1'b0;
                end else if (match_onehot[gi]) begin
                    resolved_reg <= 1'b1;
                end
            end

            // Capture the branch outcome when its resolution matches
            always_ff @(posedge clk) begin
                if (rst) begin
                    pred_reg   <= 1'b0;
                    actual_reg <= 1'b0;
                end else if (match_onehot[gi] && !flush_now) begin
                    pred_reg   <= res.pred;
                    actual_reg <= res.actual;
                end
            end

            // Payload written once at allocation; only read while busy
            always_ff @(posedge clk) begin
                if (alloc_fire && tail_slot == SLOT) begin
                    rob_index_reg <= alloc_rob_index;
                    pc_reg        <= alloc_pc;
                    alt_pc_reg    <= alloc_alt_pc;
                end
            end

            assign busy_vec[gi]      = busy_reg;
            assign resolved_vec[gi]  = resolved_reg;
            assign pred_vec[gi]      = pred_reg;
            assign actual_vec[gi]    = actual_reg;
            assign rob_index_arr[gi] = rob_index_reg;
            assign pc_arr[gi]        = pc_reg;
            assign alt_pc_arr[gi]    = alt_pc_reg;
        end
    endgenerate

    // Head/tail advance; a flush snaps both back to slot 0
    always_ff @(posedge clk) begin
        if (rst || flush_now) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            if (alloc_fire) tail_reg <= tail_reg + PTR_ONE;
            if (retire_now) head_reg <= head_reg + PTR_ONE;
        end
    end

    // Registered retirement outputs: pulses every cycle, data held between retires
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_valid     <= 1'b0;
            commit_rob_index <= '0;
            flush_out        <= 1'b0;
            redirect_pc      <= '0;
            bp_update_valid  <= 1'b0;
            bp_update_pc     <= '0;
            bp_update_taken  <= 1'b0;
        end else begin
            commit_valid    <= retire_now;
            bp_update_valid <= retire_now;
            flush_out       <= flush_now;
            if (retire_now) begin
                commit_rob_index <= rob_index_arr[head_slot];
                bp_update_pc     <= pc_arr[head_slot];
                bp_update_taken  <= actual_vec[head_slot];
            end
            if (flush_now) begin
                redirect_pc <= alt_pc_arr[head_slot];
            end
        end
    end

endmodule

// File: doc/branch_commit_unit.md
Name: branch_commit_unit

Overview:
- Consumes branch-resolution results from the branch reservation station (valid, ROB index, 2-bit {predicted, actual}).
- Holds dispatched branches in program order and matches results to them out of order.
- Retires branches in order, one per cycle at most.
- On a misprediction it issues a pipeline flush plus redirect PC; every retired branch produces a predictor-update pulse.

Parameters:
- DEPTH, 4, number of in-flight branch entries; power of two.
- PTR_W, 2, log2(DEPTH).
- IDX_W, `ROB_Entry_Width, ROB index width from defines.v.
- ADDR_W, 32, instruction address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- alloc_valid  in  1  decoder dispatches a branch this cycle
- alloc_rob_index  in  IDX_W  ROB index assigned to the branch
- alloc_pc  in  ADDR_W  PC of the branch instruction
- alloc_alt_pc  in  ADDR_W  PC of the path not predicted (redirect target on mispredict)
- alloc_stall  out  1  queue full; decoder must hold the branch
- bra_in_valid  in  1  resolution valid (from branch ALU rob_out_valid)
- bra_in_index  in  IDX_W  ROB index of the resolved branch
- bra_in_result  in  2  {predicted_taken, actual_taken}
- commit_valid  out  1  one-cycle pulse: head branch retired
- commit_rob_index  out  IDX_W  ROB index of the retired branch
- flush_out  out  1  one-cycle pulse: retired branch mispredicted
- redirect_pc  out  ADDR_W  fetch redirect target, valid with flush_out
- bp_update_valid  out  1  predictor-update pulse, equal to commit_valid
- bp_update_pc  out  ADDR_W  PC of the retired branch
- bp_update_taken  out  1  actual direction of the retired branch

Behaviour:
- Storage: circular queue of DEPTH entries. Each entry holds {busy, resolved, rob_index, pc, alt_pc, pred, actual}.
- Pointers: head and tail are PTR_W+1 bits, with the extra bit for wrap. Full when the low bits are equal and the MSBs differ; empty when the pointers are equal.
- Reset (rst=1 at an edge): clears all busy bits and both pointers; commit_valid, flush_out and bp_update_valid go to 0; all data outputs go to 0. Reset takes effect mid-operation with no drain.
- alloc_stall: combinational, equals full. When full, alloc_valid is ignored even if the head retires in the same cycle (conservative).
- Allocation: if alloc_valid and not full, at the edge write the tail entry with busy=1, resolved=0, then tail+1.
- Resolution: if bra_in_valid, CAM-compare bra_in_index against every entry with busy=1 and resolved=0.
  - On a match, at the edge set resolved=1, pred=result[1], actual=result[0].
  - No match: ignore silently. This covers a stale result after a flush.
  - More than one match is illegal.
- Retirement: evaluated on the state registered before the edge. If the head entry is busy and resolved, at the edge:
  - commit_valid=1, commit_rob_index=head.rob_index;
  - bp_update_valid=1, bp_update_pc=head.pc, bp_update_taken=head.actual;
  - head+1, busy cleared.
  - Otherwise the pulses are 0 and the data outputs hold their values.
- Latency: a resolution sampled at edge E retires the head no earlier than edge E+1, and the outputs are visible in the cycle after E+1. The minimum resolve-to-commit latency is 1 cycle.
- Mispredict (head.pred != head.actual on retire), at the same edge:
  - flush_out=1 and redirect_pc=head.alt_pc;
  - all entries are cleared and head=tail=0;
  - an allocation in that cycle is dropped;
  - a resolution in that cycle is dropped.
  - The next cycle shows an empty queue and alloc_stall=0.
- Simultaneous events: allocate, resolve and retire of different entries all proceed in the same cycle. A resolve that targets the head takes effect at the edge and retires on the following edge.
- Wrap-around: pointers wrap modulo 2*DEPTH, so a full queue is correctly distinguished from an empty one.

Decomposition:
- Shared package/defines (defines.v): ROB_Entry_Width, the branch-result bit positions (pred = bit 1, actual = bit 0), and the entry field widths.
- One natural sub-module, branch_cam_match: a DEPTH-wide index comparator that returns a one-hot match vector. Retirement and pointer logic stay in the top module.

Test Plan:
- Reset and single branch: assert rst for 2 cycles, then check all outputs are 0. Allocate idx=5, pc=0x100, alt=0x200. Resolve idx=5, result=2'b11. The next edge gives commit_valid=1, commit_rob_index=5, bp_update_taken=1 and flush_out=0.
- Out-of-order resolution: allocate idx 1,2,3, then resolve 3, 2, 1 in consecutive cycles. No commit occurs until idx1 resolves; after that commits appear as 1, 2, 3 on three consecutive cycles.
- Mispredict flush: allocate idx 4 (alt=0x3C0) and idx 6. Resolve idx4 with 2'b10. The result is flush_out=1, redirect_pc=0x3C0 and commit_rob_index=4. The next cycle the queue is empty; a later resolve of idx6 produces no commit.
- Full and wrap: allocate 4 branches and check alloc_stall=1 and that a 5th alloc is ignored. Retire 2, allocate 2 more so the tail wraps. All 4 retire in order with correct indices.
- Simultaneous events: in one cycle, allocate idx7, resolve the head and retire the previously resolved head. All three take effect, with no lost allocation or resolution.
- Reset mid-operation: assert rst with 3 busy entries and a pending resolve. Afterwards the queue is empty, no commit pulse occurs, and alloc_stall=0.
